// File: rtl/ff_pkg.sv
// Shared definitions for the field-arithmetic arbiters: field width, the
// 25519 prime and the arbiter state encoding.
package ff_pkg;

    localparam int FIELD_W = 255;

    // p = 2^255 - 19
    localparam logic [FIELD_W-1:0] P_25519 = {{247{1'b1}}, 8'hed};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    // Width of an index into n requesters; never zero so ports stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ff_rr_pick.sv
// Rotate-priority one-hot picker: first set bit of req at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is zero when req is zero.
module ff_rr_pick
    import ff_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ffs_arbiter.sv
// Round-robin share of one ffs subtractor among NREQ requesters; optional WAIT watchdog under FFS_ARB_TIMEOUT_EN.
// Latency: accept at cycle 0, ffs_start cycle 1, rsp_valid cycle L+2 for an ffs latency of L.
// Backpressure: req_ready is a one-hot grant offered only in IDLE; one operation in flight at a time.
module ffs_arbiter
    import ff_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int W              = FIELD_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_result,
    output logic              rsp_err,
    output logic              ffs_start,
    output logic [W-1:0]      ffs_a,
    output logic [W-1:0]      ffs_b,
    input  logic [W-1:0]      ffs_result,
    input  logic              ffs_valid,
    output logic              busy
);

    localparam int IW = idx_w(NREQ);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } opnd_t;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, owner_q, win_idx;
    logic [NREQ-1:0] pick_req, grant;
    logic          accept, done, timeout;
    opnd_t         opnd_q;

    // Masking the picker input outside IDLE keeps req_ready low in every other state.
    assign pick_req = (state_q == IDLE) ? req_valid : '0;

    ff_rr_pick #(
        .N(NREQ)
    ) u_pick (
        .req  (pick_req),
        .ptr  (ptr_q),
        .grant(grant),
        .index(win_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign done      = (state_q == WAIT) && ffs_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (ffs_valid || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            opnd_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            opnd_q.a <= req_a[win_idx*W +: W];
            opnd_q.b <= req_b[win_idx*W +: W];
            owner_q  <= win_idx;
            ptr_q    <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    // A timed-out operation reports a zero result alongside rsp_err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_result <= '0;
        end else if (done) begin
            rsp_result <= ffs_result;
        end else if (timeout) begin
            rsp_result <= '0;
        end
    end

`ifdef FFS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_q != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // ffs_valid in the final WAIT cycle still counts as a good result.
    assign timeout = (state_q == WAIT) && !ffs_valid &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (done) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign ffs_start = (state_q == ISSUE);
    assign ffs_a     = opnd_q.a;
    assign ffs_b     = opnd_q.b;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ffs_arbiter.sv
// Directed bench for ffs_arbiter with a two-cycle (a-b) mod p subtractor stub.
// The timeout scenario follows FFS_ARB_TIMEOUT_EN.
module tb_ffs_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 255;
    localparam int TO   = 8;

    localparam logic [W-1:0] P    = {{247{1'b1}}, 8'hed};
    localparam logic [W-1:0] NEG7 = {{247{1'b1}}, 8'he6};

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_result;
    logic              rsp_err;
    logic              ffs_start;
    logic [W-1:0]      ffs_a;
    logic [W-1:0]      ffs_b;
    logic [W-1:0]      ffs_result = '0;
    logic              ffs_valid  = 1'b0;
    logic              busy;

    logic              stub_mute;
    logic [1:0]        stub_dly = 2'd0;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    ffs_arbiter #(
        .NREQ          (NREQ),
        .W             (W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_result(rsp_result),
        .rsp_err   (rsp_err),
        .ffs_start (ffs_start),
        .ffs_a     (ffs_a),
        .ffs_b     (ffs_b),
        .ffs_result(ffs_result),
        .ffs_valid (ffs_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        if (a >= b) t = {1'b0, a} - {1'b0, b};
        else        t = {1'b0, a} + {1'b0, P} - {1'b0, b};
        return t[W-1:0];
    endfunction

    // ffs stub: valid and result appear two cycles after the start pulse.
    always @(posedge clk) begin
        ffs_valid <= 1'b0;
        if (stub_dly != 2'd0) begin
            stub_dly <= stub_dly - 2'd1;
            if (stub_dly == 2'd1 && !stub_mute) begin
                ffs_valid  <= 1'b1;
                ffs_result <= sub_mod(ffs_a, ffs_b);
            end
        end
        if (ffs_start) stub_dly <= 2'd1;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
    endtask

    logic [3:0] gnt3 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int         res3 [4] = '{19, 38, 57, 76};

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        stub_mute = 1'b0;
        cyc(2);
        check("rst_ready",  256'(req_ready),  256'(0));
        check("rst_rspv",   256'(rsp_valid),  256'(0));
        check("rst_result", 256'(rsp_result), 256'(0));
        check("rst_err",    256'(rsp_err),    256'(0));
        check("rst_start",  256'(ffs_start),  256'(0));
        check("rst_a",      256'(ffs_a),      256'(0));
        check("rst_b",      256'(ffs_b),      256'(0));
        check("rst_busy",   256'(busy),       256'(0));
        rst = 1'b1;
        cyc(1);

        // Single request on port 2: 10 - 3
        set_op(2, 255'd10, 255'd3);
        req_valid = 4'b0100;
        #1 check("t1_ready", 256'(req_ready), 256'(4'b0100));
        cyc(1);
        req_valid = '0;
        check("t1_start", 256'(ffs_start), 256'(1));
        check("t1_a",     256'(ffs_a),     256'(10));
        check("t1_b",     256'(ffs_b),     256'(3));
        check("t1_busy",  256'(busy),      256'(1));
        check("t1_noready", 256'(req_ready), 256'(0));
        cyc(1);
        check("t1_start_pulse", 256'(ffs_start), 256'(0));
        cyc(1);
        check("t1_early_rsp", 256'(rsp_valid), 256'(0));
        cyc(1);
        check("t1_rspv",   256'(rsp_valid),  256'(4'b0100));
        check("t1_result", 256'(rsp_result), 256'(7));
        check("t1_err",    256'(rsp_err),    256'(0));
        cyc(1);
        check("t1_rspv_off", 256'(rsp_valid),  256'(0));
        check("t1_idle",     256'(busy),       256'(0));
        check("t1_hold",     256'(rsp_result), 256'(7));

        // Port 1: 3 - 10 wraps to p - 7; operands pass through unreduced
        set_op(1, 255'd3, 255'd10);
        req_valid = 4'b0010;
        #1 check("t2_ready", 256'(req_ready), 256'(4'b0010));
        cyc(1);
        req_valid = '0;
        check("t2_a", 256'(ffs_a), 256'(3));
        check("t2_b", 256'(ffs_b), 256'(10));
        cyc(3);
        check("t2_rspv",   256'(rsp_valid),  256'(4'b0010));
        check("t2_result", 256'(rsp_result), 256'(NEG7));
        cyc(1);

        rst = 1'b0;
        cyc(1);
        rst = 1'b1;

        // All four ports held after reset: grants 0,1,2,3, five cycles apart
        for (int k = 0; k < 4; k++) set_op(k, W'(20 * (k + 1)), W'(k + 1));
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("t3_ready%0d", k), 256'(req_ready), 256'(gnt3[k]));
            cyc(2);
            check($sformatf("t3_noready%0d", k), 256'(req_ready), 256'(0));
            cyc(2);
            check($sformatf("t3_rspv%0d", k),   256'(rsp_valid),  256'(gnt3[k]));
            check($sformatf("t3_result%0d", k), 256'(rsp_result), 256'(res3[k]));
            if (k == 3) req_valid = '0;
            cyc(1);
        end

        // Ports 0 and 1 continuously requesting: grants alternate
        set_op(0, 255'd50, 255'd8);
        set_op(1, 255'd9,  255'd4);
        req_valid = 4'b0011;
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("t4_ready%0d", k), 256'(req_ready),
                     256'((k % 2 == 0) ? 4'b0001 : 4'b0010));
            cyc(4);
            check($sformatf("t4_rspv%0d", k), 256'(rsp_valid),
                  256'((k % 2 == 0) ? 4'b0001 : 4'b0010));
            check($sformatf("t4_result%0d", k), 256'(rsp_result),
                  256'((k % 2 == 0) ? 42 : 5));
            if (k == 5) req_valid = '0;
            cyc(1);
        end

        // Reset while WAIT: the stub's late valid must be ignored
        set_op(3, 255'd77, 255'd7);
        req_valid = 4'b1000;
        #1 check("t5_ready", 256'(req_ready), 256'(4'b1000));
        cyc(1);
        req_valid = '0;
        cyc(1);
        check("t5_wait_busy", 256'(busy), 256'(1));
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("t5_rspv",   256'(rsp_valid),  256'(0));
        check("t5_busy",   256'(busy),       256'(0));
        check("t5_a",      256'(ffs_a),      256'(0));
        check("t5_b",      256'(ffs_b),      256'(0));
        check("t5_result", 256'(rsp_result), 256'(0));
        check("t5_start",  256'(ffs_start),  256'(0));
        cyc(1);
        check("t5_rspv_late", 256'(rsp_valid), 256'(0));
        check("t5_busy_late", 256'(busy),      256'(0));
        cyc(1);

        // Normal op so the timeout result has a nonzero value to overwrite
        set_op(2, 255'd30, 255'd1);
        req_valid = 4'b0100;
        #1 check("t6_ready", 256'(req_ready), 256'(4'b0100));
        cyc(1);
        req_valid = '0;
        cyc(3);
        check("t6_result", 256'(rsp_result), 256'(29));
        cyc(1);

        // ffs never answers
        stub_mute = 1'b1;
        set_op(0, 255'd5, 255'd1);
        req_valid = 4'b0001;
        #1 check("t7_ready", 256'(req_ready), 256'(4'b0001));
        cyc(1);
        req_valid = '0;
`ifdef FFS_ARB_TIMEOUT_EN
        cyc(8);
        check("t7_not_yet", 256'(rsp_valid), 256'(0));
        check("t7_busy",    256'(busy),      256'(1));
        cyc(1);
        check("t7_rspv",   256'(rsp_valid),  256'(4'b0001));
        check("t7_err",    256'(rsp_err),    256'(1));
        check("t7_result", 256'(rsp_result), 256'(0));
        cyc(1);
        check("t7_idle", 256'(busy),      256'(0));
        check("t7_off",  256'(rsp_valid), 256'(0));
`else
        cyc(100);
        check("t7_busy_stuck", 256'(busy),      256'(1));
        check("t7_no_rsp",     256'(rsp_valid), 256'(0));
        check("t7_err",        256'(rsp_err),   256'(0));
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("t7_recover", 256'(busy), 256'(0));
`endif
        stub_mute = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
